// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug TX serializer.
// DBG_TX_CHECKSUM_EN adds the CSUM state for the trailing XOR byte.
package dbg_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 2;

`ifdef DBG_TX_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    // Number of real bytes held in a DATA_W-bit word.
    function automatic int bytes_in(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/dbg_byte_select.sv
// Combinational pick of one byte from the captured word, honouring byte order.
// Positions past the end of the word read as 0x00.
module dbg_byte_select
    import dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b0
)
(
    input  logic [DATA_W-1:0] data_word,
    input  logic [CNT_W-1:0]  size,
    input  logic [CNT_W-1:0]  index,
    output logic [BYTE_W-1:0] sel_byte
);

    localparam int NBYTES = bytes_in(DATA_W);

    logic [CNT_W-1:0] pos;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        pos      = MSB_FIRST ? (size - index) : index;
        sel_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (pos == i[CNT_W-1:0]) begin
                sel_byte = data_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/debug_tx_serializer.sv
// Serializes a captured debug word as size+1 bytes over a valid/ready link.
// Optional DBG_TX_CHECKSUM_EN appends an XOR checksum byte before done.
module debug_tx_serializer
    import dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b0
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] result,
    input  logic [1:0]        size,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic              cmd_drop
);

    state_t            state;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  size_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  index_q;
`ifdef DBG_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    logic [DATA_W-1:0] sel_word;
    logic [CNT_W-1:0]  sel_size;
    logic [CNT_W-1:0]  sel_index;
    logic [BYTE_W-1:0] sel_byte;
    logic              xfer;

    assign xfer = tx_valid && tx_ready;

    // In IDLE the selector looks at the incoming command so byte 0 is ready on capture;
    // otherwise it looks one byte ahead so tx_data can advance right on a transfer.
    always_comb begin
        if (state == IDLE) begin
            sel_word  = result;
            sel_size  = size;
            sel_index = '0;
        end else begin
            sel_word  = word_q;
            sel_size  = size_q;
            sel_index = index_q + CNT_W'(1);
        end
    end

    dbg_byte_select #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_byte_select (
        .data_word (sel_word),
        .size      (sel_size),
        .index     (sel_index),
        .sel_byte  (sel_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word_q      <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_drop    <= 1'b0;
`ifdef DBG_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            cmd_drop <= cmd_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        word_q      <= result;
                        size_q      <= size;
                        remaining_q <= size;
                        index_q     <= '0;
                        tx_data     <= sel_byte;
                        tx_valid    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SEND;
`ifdef DBG_TX_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                    end
                end
                SEND: begin
                    if (xfer) begin
`ifdef DBG_TX_CHECKSUM_EN
                        csum_q <= csum_q ^ tx_data;
`endif
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            index_q     <= index_q + CNT_W'(1);
                            tx_data     <= sel_byte;
                        end else begin
`ifdef DBG_TX_CHECKSUM_EN
                            tx_data <= csum_q ^ tx_data;
                            state   <= CSUM;
`else
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
`endif
                        end
                    end
                end
`ifdef DBG_TX_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Scoreboard bench: three serializers (32b LSB-first, 32b MSB-first, 16b LSB-first)
// share one stimulus stream; a negedge monitor checks every accepted byte.
module tb_debug_tx_serializer;

`ifdef DBG_TX_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] result    = '0;
    logic [1:0]  size      = '0;
    logic        tx_ready  = 1'b0;

    logic [2:0][7:0] txd;
    logic [2:0]      txv, bsy, dn, drp;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt[3] = '{0, 0, 0};
    int drop_cnt[3] = '{0, 0, 0};

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    logic [2:0]      prev_stall = '0;
    logic [2:0][7:0] prev_data  = '0;

    always #5 clock = ~clock;

    debug_tx_serializer #(.DATA_W(32), .MSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .result(result), .size(size),
        .tx_ready(tx_ready), .tx_data(txd[0]), .tx_valid(txv[0]), .busy(bsy[0]),
        .done(dn[0]), .cmd_drop(drp[0]));

    debug_tx_serializer #(.DATA_W(32), .MSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .result(result), .size(size),
        .tx_ready(tx_ready), .tx_data(txd[1]), .tx_valid(txv[1]), .busy(bsy[1]),
        .done(dn[1]), .cmd_drop(drp[1]));

    debug_tx_serializer #(.DATA_W(16), .MSB_FIRST(1'b0)) dut2 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .result(result[15:0]), .size(size),
        .tx_ready(tx_ready), .tx_data(txd[2]), .tx_valid(txv[2]), .busy(bsy[2]),
        .done(dn[2]), .cmd_drop(drp[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte k of a response for instance d: d1 is MSB-first, d2 only holds 2 real bytes.
    function automatic logic [7:0] model_byte(input logic [31:0] w, input logic [1:0] sz,
                                              input int k, input int d);
        int pos;
        int nb;
        pos = (d == 1) ? (int'(sz) - k) : k;
        nb  = (d == 2) ? 2 : 4;
        if (pos < nb) return w[pos*8 +: 8];
        return 8'h00;
    endfunction

    function automatic int q_size(input int d);
        if (d == 0) return q0.size();
        if (d == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic logic [7:0] q_pop(input int d);
        if (d == 0) return q0.pop_front();
        if (d == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    task automatic q_push(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else if (d == 1) q1.push_back(b);
        else q2.push_back(b);
    endtask

    task automatic expect_cmd(input logic [31:0] w, input logic [1:0] sz);
        for (int d = 0; d < 3; d++) begin
            logic [7:0] x;
            logic [7:0] b;
            x = 8'h00;
            for (int k = 0; k <= int'(sz); k++) begin
                b = model_byte(w, sz, k, d);
                x = x ^ b;
                q_push(d, b);
            end
`ifdef DBG_TX_CHECKSUM_EN
            q_push(d, x);
`endif
        end
    endtask

    // Drives cmd_valid for one cycle; returns one tick after the capture edge.
    task automatic issue(input logic [31:0] w, input logic [1:0] sz, input bit accepted);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        result    = w;
        size      = sz;
        if (accepted) expect_cmd(w, sz);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clock); #1;
            i++;
        end while ((bsy != 3'b000 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0)
                   && i < 200);
        check({tag, "_settle"}, 32'(i < 200), 1);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (prev_stall[d]) begin
                    check($sformatf("hold_valid_d%0d", d), 32'(txv[d]), 1);
                    check($sformatf("hold_data_d%0d", d), 32'(txd[d]), 32'(prev_data[d]));
                end
                if (txv[d] && tx_ready) begin
                    if (q_size(d) == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL extra_byte_d%0d: got %0h, expected no byte", d, txd[d]);
                    end else begin
                        check($sformatf("byte_d%0d", d), 32'(txd[d]), 32'(q_pop(d)));
                    end
                end
                if (dn[d]) begin
                    done_cnt[d]++;
                    check($sformatf("done_after_last_d%0d", d), q_size(d), 0);
                end
                if (drp[d]) drop_cnt[d]++;
                prev_stall[d] = txv[d] && !tx_ready;
                prev_data[d]  = txd[d];
            end
        end
    end

    initial begin
        int drops_before;
        int i;
        logic [4:0] pat;

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_tx_valid", 32'(txv), 0);
        check("rst_tx_data", 32'(txd[0]), 0);
        check("rst_busy", 32'(bsy), 0);
        check("rst_done", 32'(dn), 0);
        check("rst_cmd_drop", 32'(drp), 0);

        // 4 bytes, ready held high: exact cycle timing on dut0
        @(posedge clock); #1;
        tx_ready  = 1'b1;
        cmd_valid = 1'b1;
        result    = 32'hA1B2_C3D4;
        size      = 2'd3;
        expect_cmd(32'hA1B2_C3D4, 2'd3);
        for (int c = 1; c <= 6 + EXTRA; c++) begin
            @(posedge clock); #1;
            cmd_valid = 1'b0;
            @(negedge clock);
            check($sformatf("t1_valid_c%0d", c), 32'(txv[0]), 32'(c <= 4 + EXTRA));
            check($sformatf("t1_done_c%0d", c), 32'(dn[0]), 32'(c == 5 + EXTRA));
            check($sformatf("t1_busy_c%0d", c), 32'(bsy[0]), 32'(c <= 5 + EXTRA));
            if (c == 1) check("t1_first_byte", 32'(txd[0]), 32'hD4);
        end
        wait_idle("t1");

        // Stalled handshake: ready pattern 0,0,1,0,1
        tx_ready = 1'b0;
        issue(32'h0000_12EF, 2'd1, 1'b1);
        pat = 5'b10100;
        for (int k = 0; k < 5; k++) begin
            tx_ready = pat[k];
            @(posedge clock); #1;
            if (k == 1) check("t2_stall_byte", 32'(txd[0]), 32'hEF);
        end
        tx_ready = 1'b1;
        @(negedge clock);
        check("t2_done_timing", 32'(dn[0]), 32'(EXTRA == 0));
        wait_idle("t2");

        // Byte order and zero-fill past the 16-bit word
        issue(32'h1122_3344, 2'd2, 1'b1);
        wait_idle("t3");

        // Command during a transfer is dropped, original bytes untouched
        drops_before = drop_cnt[0];
        issue(32'hCAFE_F00D, 2'd3, 1'b1);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        result    = 32'hDEAD_BEEF;
        size      = 2'd0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        wait_idle("t4");
        check("t4_drop_count", drop_cnt[0] - drops_before, 1);

        // Command in the DONE cycle is dropped too
        drops_before = drop_cnt[0];
        issue(32'h0000_0077, 2'd0, 1'b1);
        i = 0;
        while (!dn[0] && i < 50) begin
            @(negedge clock);
            i++;
        end
        check("t4b_done_seen", 32'(dn[0]), 1);
        #1;
        cmd_valid = 1'b1;
        result    = 32'h0000_0099;
        size      = 2'd0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        wait_idle("t4b");
        check("t4b_drop_count", drop_cnt[0] - drops_before, 1);

        // Checksum vector (plain data bytes when the checksum is off)
        issue(32'h0102_0304, 2'd3, 1'b1);
        wait_idle("t6");

        // Reset while byte 2 of 4 is pending
        issue(32'h89AB_CDEF, 2'd3, 1'b1);
        @(posedge clock); #1;
        tx_ready = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(txv), 0);
        check("t5_rst_busy", 32'(bsy), 0);
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tx_ready = 1'b1;
        issue(32'h0000_005A, 2'd0, 1'b1);
        @(negedge clock);
        check("t5_restart_byte", 32'(txd[0]), 32'h5A);
        wait_idle("t5");

        for (int d = 0; d < 3; d++) begin
            check($sformatf("done_total_d%0d", d), done_cnt[d], 7);
            check($sformatf("drop_total_d%0d", d), drop_cnt[d], 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/debug_tx_serializer.md
Name: debug_tx_serializer

Overview:
- Downstream consumer of the debug decoder's 32-bit `result` and 2-bit `size` outputs.
- On each accepted command it captures the result word and emits `size+1` bytes, least-significant byte first by default, to the UART transmitter over a valid/ready byte handshake.
- It sits between the debug decoder and the UART TX, so the host PC reads back pipeline-stage values one byte at a time.

Parameters:
- DATA_W, 32, width of the captured result word; must be a multiple of 8 and at most 32.
- MSB_FIRST, 0, byte order: 0 sends byte 0 (bits 7:0) first; 1 sends byte `size` first.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  one-cycle strobe: a new debug code has been decoded and `result`/`size` are stable this cycle.
- result  in  DATA_W  value selected by the debug decoder.
- size  in  2  byte count minus one (0 gives 1 byte, 3 gives 4 bytes).
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_data  out  8  byte being offered.
- tx_valid  out  1  tx_data is valid; held until accepted.
- busy  out  1  high from capture until the cycle after the last byte is accepted.
- done  out  1  one-cycle pulse after the final byte (or checksum byte) is accepted.
- cmd_drop  out  1  one-cycle pulse when cmd_valid arrives while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE, tx_valid=0, tx_data=0, busy=0, done=0, cmd_drop=0, shift register=0, byte counter=0.
- IDLE: on cmd_valid, capture result and size and load remaining count = size. Go to SEND next edge. No other outputs change in this state.
- SEND: tx_valid=1 and tx_data = current byte, selected by MSB_FIRST and the byte index.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
  - A transfer occurs on an edge where tx_valid && tx_ready.
  - On transfer with remaining count >0: decrement count, advance the index, and present the next byte the following cycle. tx_valid stays 1, so back-to-back transfers are possible when tx_ready is held high.
  - On transfer with remaining count ==0: go to DONE.
- DONE: tx_valid=0, done=1 for exactly one cycle, busy=1; next state IDLE.
- busy=1 in SEND and DONE, 0 in IDLE.
- Latency: first tx_valid is asserted the cycle after cmd_valid. With tx_ready held high, an N-byte response takes N cycles of tx_valid and done fires at cycle N+1.
- cmd_valid while busy: the command is ignored, cmd_drop pulses for 1 cycle, and the captured data is unaffected.
- cmd_valid in the same cycle that DONE is active: dropped, with cmd_drop asserted. A new command is accepted only in IDLE.
- size=3 with DATA_W=32 sends all 4 bytes. If size exceeds DATA_W/8-1, the excess bytes are sent as 0x00.
- tx_ready high while tx_valid=0 has no effect.
- Reset mid-transfer: tx_valid drops immediately (async), no partial state survives, and the next command restarts from byte 0.

Optional Feature:
- Macro: DBG_TX_CHECKSUM_EN.
- When defined: after the last data byte is accepted, the FSM enters state CSUM and sends one extra byte, the XOR of all data bytes sent, using the same handshake. done pulses after the checksum byte is accepted, so an N-byte response becomes N+1 transfers.
- When undefined: state CSUM and the XOR accumulator are absent, and behaviour is exactly as above.

Decomposition:
- Package dbg_pkg:
  - FSM state encoding: IDLE, SEND, CSUM, DONE.
  - BYTE_W=8.
  - CNT_W=2.
  - Byte-index helper constant for DATA_W/8.
- One sub-module, dbg_byte_select: combinational selection of byte[index] from the captured word, honouring MSB_FIRST and the zero-fill rule. The FSM, counter and handshake stay in the top module.

Test Plan:
- result=0xA1B2C3D4, size=3, MSB_FIRST=0, tx_ready=1 constantly -> tx_data D4,C3,B2,A1 on 4 consecutive cycles starting 1 cycle after cmd_valid; done at cycle 5; busy low at cycle 6.
- result=0x000012EF, size=1, tx_ready toggling 0,0,1,0,1 -> EF held stable until the first accept, then 12; done after the second accept; no glitch on tx_data during stalls.
- MSB_FIRST=1, result=0x11223344, size=2 -> bytes 22,33,44.
- cmd_valid pulsed in the second cycle of a 4-byte transfer with a different result -> cmd_drop pulses once and the original 4 bytes are unchanged.
- Reset asserted while byte 2 of 4 is pending -> tx_valid=0 immediately; a new command with size=0, result=0x5A yields a single 5A byte.
- With DBG_TX_CHECKSUM_EN, result=0x01020304, size=3 -> bytes 04,03,02,01, then 04 (the XOR); done after the 5th accept.
